// File: rtl/hazard_unit.sv
// Pipeline hazard controller: combinational hold/clear for PC and pipeline registers plus a mult/div busy tracker.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module hazard_unit #(
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] ex_rt,
    input  logic       ex_memread,
    input  logic       ex_branch_taken,
    input  logic       ex_md_start,
    input  logic       id_md_use,
    input  logic       mem_wait,
    output logic       hold_pc,
    output logic       hold_ifid,
    output logic       clear_ifid,
    output logic       hold_idex,
    output logic       clear_idex,
    output logic       hold_exmem,
    output logic       clear_exmem,
    output logic       hold_memwb,
    output logic       md_busy,
    output logic       md_done
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    localparam int CW = $clog2(MD_LAT);
    localparam logic [CW-1:0] CNT_INIT = CW'(MD_LAT - 1);

    if (MD_LAT < 2 || CNT_W < 1) begin : g_bad_params
        $error("hazard_unit: MD_LAT must be >= 2 and CNT_W >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } md_state_e;

    md_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic md_start_acc;
    logic load_use;
    logic md_stall;

    // A start is only taken when the mult/div actually leaves EX this cycle.
    assign md_start_acc = ex_md_start & ~mem_wait & ~ex_branch_taken;
    assign load_use     = ex_memread && (ex_rt != 5'd0) &&
                          ((ex_rt == id_rs) || (ex_rt == id_rt));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (md_start_acc) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (md_start_acc) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        md_busy     = (state_q == S_BUSY);
        md_done     = (state_q == S_DONE);
        md_stall    = id_md_use && (state_q == S_BUSY);
        hold_pc     = 1'b0;
        hold_ifid   = 1'b0;
        clear_ifid  = 1'b0;
        hold_idex   = 1'b0;
        clear_idex  = 1'b0;
        hold_exmem  = 1'b0;
        clear_exmem = 1'b0;
        hold_memwb  = 1'b0;
        if (reset) begin
            hold_pc = 1'b0;
        end else if (mem_wait) begin
            // Freeze everything; a taken branch in EX re-presents once memory is ready.
            hold_pc    = 1'b1;
            hold_ifid  = 1'b1;
            hold_idex  = 1'b1;
            hold_exmem = 1'b1;
            hold_memwb = 1'b1;
        end else if (ex_branch_taken) begin
            clear_ifid = 1'b1;
            clear_idex = 1'b1;
        end else if (load_use || md_stall) begin
            hold_pc    = 1'b1;
            hold_ifid  = 1'b1;
            clear_idex = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] flush_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (hold_ifid && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 1'b1;
            end
            if (clear_ifid && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table, directed multi-cycle sequences, then random traffic vs a counting model.
module tb_hazard_unit;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;

    // Control vector bit order: hold_pc, hold_ifid, clear_ifid, hold_idex, clear_idex, hold_exmem, clear_exmem, hold_memwb
    localparam logic [7:0] CTL_NONE  = 8'b0000_0000;
    localparam logic [7:0] CTL_WAIT  = 8'b1101_0101;
    localparam logic [7:0] CTL_FLUSH = 8'b0010_1000;
    localparam logic [7:0] CTL_STALL = 8'b1100_1000;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       ex_memread, ex_branch_taken, ex_md_start, id_md_use, mem_wait;
    logic       hold_pc, hold_ifid, clear_ifid, hold_idex, clear_idex;
    logic       hold_exmem, clear_exmem, hold_memwb, md_busy, md_done;
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cycles, flush_count;
`endif

    hazard_unit #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .ex_rt           (ex_rt),
        .ex_memread      (ex_memread),
        .ex_branch_taken (ex_branch_taken),
        .ex_md_start     (ex_md_start),
        .id_md_use       (id_md_use),
        .mem_wait        (mem_wait),
        .hold_pc         (hold_pc),
        .hold_ifid       (hold_ifid),
        .clear_ifid      (clear_ifid),
        .hold_idex       (hold_idex),
        .clear_idex      (clear_idex),
        .hold_exmem      (hold_exmem),
        .clear_exmem     (clear_exmem),
        .hold_memwb      (hold_memwb),
        .md_busy         (md_busy),
        .md_done         (md_done)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ctl;
    assign ctl = {hold_pc, hold_ifid, clear_ifid, hold_idex, clear_idex,
                  hold_exmem, clear_exmem, hold_memwb};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: remaining busy cycles, a done flag and plain counters.
    int m_busy_left = 0;
    bit m_done      = 1'b0;
    int m_stall     = 0;
    int m_flush     = 0;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_ctl();
        bit lu;
        bit mds;
        lu  = ex_memread && (ex_rt != 0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
        mds = id_md_use && (m_busy_left > 0);
        if (reset)           return CTL_NONE;
        if (mem_wait)        return CTL_WAIT;
        if (ex_branch_taken) return CTL_FLUSH;
        if (lu || mds)       return CTL_STALL;
        return CTL_NONE;
    endfunction

    task automatic model_edge();
        logic [7:0] e;
        bit acc;
        e   = exp_ctl();
        acc = ex_md_start && !mem_wait && !ex_branch_taken;
        if (reset) begin
            m_busy_left = 0;
            m_done      = 1'b0;
            m_stall     = 0;
            m_flush     = 0;
        end else begin
            if (e[6] && m_stall < CNT_MAX) m_stall++;
            if (e[5] && m_flush < CNT_MAX) m_flush++;
            if (m_busy_left > 0) begin
                m_busy_left--;
                m_done = (m_busy_left == 0);
            end else begin
                m_done = 1'b0;
                if (acc) m_busy_left = MD_LAT;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ctl"}, 32'(ctl), 32'(exp_ctl()));
        chk({tag, ".busy"}, 32'(md_busy), 32'(m_busy_left > 0));
        chk({tag, ".done"}, 32'(md_done), 32'(m_done));
`ifdef HAZARD_STATS_EN
        chk({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(m_stall));
        chk({tag, ".flush_count"}, 32'(flush_count), 32'(m_flush));
`endif
    endtask

    task automatic set_in(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] ert, input logic mr, input logic br,
                          input logic st, input logic mu, input logic mw);
        reset = rst; id_rs = rs; id_rt = rt; ex_rt = ert; ex_memread = mr;
        ex_branch_taken = br; ex_md_start = st; id_md_use = mu; mem_wait = mw;
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic [4:0] rs, rt, ert;
        logic       mr, br, mu, mw;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b0, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, CTL_STALL};
        vecs[1] = '{1'b0, 5'd2, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, CTL_STALL};
        vecs[2] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, CTL_NONE};
        vecs[3] = '{1'b0, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, CTL_NONE};
        vecs[4] = '{1'b0, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, CTL_NONE};
        vecs[5] = '{1'b0, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, CTL_FLUSH};
        vecs[6] = '{1'b0, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, CTL_WAIT};
        vecs[7] = '{1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, CTL_NONE};
        vecs[8] = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, CTL_NONE};
        vecs[9] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, CTL_WAIT};

        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("reset.ctl", 32'(ctl), 32'(CTL_NONE));
        chk("reset.busy", 32'(md_busy), 32'd0);
        chk("reset.done", 32'(md_done), 32'd0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_reset.busy", 32'(md_busy), 32'd0);
`ifdef HAZARD_STATS_EN
        chk("reset.stall_cycles", 32'(stall_cycles), 32'd0);
        chk("reset.flush_count", 32'(flush_count), 32'd0);
`endif
        tick();

        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i].rst, vecs[i].rs, vecs[i].rt, vecs[i].ert, vecs[i].mr,
                   vecs[i].br, 1'b0, vecs[i].mu, vecs[i].mw);
            chk($sformatf("vec%0d.ctl", i), 32'(ctl), 32'(vecs[i].exp));
            tick();
        end

        // Load-use stalls one cycle; the bubble in EX removes the match.
        set_in(0, 5, 1, 5, 1, 0, 0, 0, 0);
        chk("lu.stall", 32'(ctl), 32'(CTL_STALL));
        tick();
        set_in(0, 5, 1, 0, 0, 0, 0, 0, 0);
        chk("lu.release", 32'(ctl), 32'(CTL_NONE));
        tick();

        // mult followed by an mfhi in ID: stall exactly MD_LAT cycles, proceed on done.
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("md.start_busy", 32'(md_busy), 32'd0);
        tick();
        for (int k = 0; k < MD_LAT; k++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
            chk($sformatf("md.busy%0d", k), 32'(md_busy), 32'd1);
            chk($sformatf("md.hold%0d", k), 32'(ctl), 32'(CTL_STALL));
            chk($sformatf("md.nodone%0d", k), 32'(md_done), 32'd0);
            tick();
        end
        chk("md.done", 32'(md_done), 32'd1);
        chk("md.done_busy", 32'(md_busy), 32'd0);
        chk("md.done_ctl", 32'(ctl), 32'(CTL_NONE));
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("md.done_once", 32'(md_done), 32'd0);
        tick();

        // Reset in the second BUSY cycle aborts with no done pulse.
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("mdrst.busy_in_reset", 32'(md_busy), 32'd1);
        chk("mdrst.ctl_in_reset", 32'(ctl), 32'(CTL_NONE));
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("mdrst.busy%0d", k), 32'(md_busy), 32'd0);
            chk($sformatf("mdrst.done%0d", k), 32'(md_done), 32'd0);
            tick();
        end

        // Starts are refused under mem_wait or a taken branch.
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 1, 1, 0, 0);
        chk("mdblk.wait", 32'(md_busy), 32'd0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mdblk.branch", 32'(md_busy), 32'd0);
        tick();

        // Start held high: ignored while busy, re-accepted in the DONE cycle.
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < MD_LAT + 1; k++) tick();
        chk("b2b.done", 32'(md_done), 32'd1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("b2b.rebusy", 32'(md_busy), 32'd1);
        chk("b2b.nodone", 32'(md_done), 32'd0);
        for (int k = 0; k < MD_LAT + 2; k++) tick();
        chk("b2b.idle", 32'(md_busy | md_done), 32'd0);

        // mem_wait over a taken branch defers the flush.
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            set_in(0, 0, 0, 0, 0, 1, 0, 0, 1);
            chk($sformatf("mw.hold%0d", k), 32'(ctl), 32'(CTL_WAIT));
            tick();
        end
        set_in(0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("mw.flush", 32'(ctl), 32'(CTL_FLUSH));
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mw.after", 32'(ctl), 32'(CTL_NONE));
`ifdef HAZARD_STATS_EN
        chk("mw.stall_cycles", 32'(stall_cycles), 32'd3);
        chk("mw.flush_count", 32'(flush_count), 32'd1);
`endif
        tick();

        for (int c = 0; c < 400; c++) begin
            set_in(($urandom_range(0, 49) == 0),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 0),
                   ($urandom_range(0, 4) == 0));
            check_all($sformatf("rnd%0d", c));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage MIPS core. It generates the synchronous `hold` and `clear` controls for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also tracks the multi-cycle multiply/divide unit with an internal state machine. It sits beside the datapath: it consumes decoded register fields and status from ID, EX and MEM, and drives the hold/clear pins of every pipeline register.

## Interface
Parameters:
- `MD_LAT`, default 32: multiply/divide latency in cycles; legal range ≥ 2.
- `CNT_W`, default 32: width of the statistics counters (used only with `HAZARD_STATS_EN`).

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `id_rs`, `id_rt` input 5 each: source register numbers of the instruction in ID.
- `ex_rt` input 5: destination register of the instruction in EX.
- `ex_memread` input 1: instruction in EX is a load.
- `ex_branch_taken` input 1: branch or jump in EX resolved taken.
- `ex_md_start` input 1: the instruction in EX is mult/div (level signal, qualified internally).
- `id_md_use` input 1: the instruction in ID is mfhi/mflo/mult/div.
- `mem_wait` input 1: data memory not ready.
- `hold_pc`, `hold_ifid`, `clear_ifid`, `hold_idex`, `clear_idex`, `hold_exmem`, `clear_exmem`, `hold_memwb` output 1 each: pipeline register controls.
- `md_busy`, `md_done` output 1 each: multiply/divide unit status.
- `stall_cycles`, `flush_count` output `CNT_W` each: present only with `HAZARD_STATS_EN`.

## Operation
Hold/clear outputs are combinational from the inputs and the current FSM state, so they act on the same clock edge the pipeline registers sample. Priority, highest first:
1. **`mem_wait`**: all `hold_*` = 1; all `clear_*` = 0. A pending branch flush is deferred, because EX is held and `ex_branch_taken` re-presents next cycle.
2. **`ex_branch_taken`**:
   - `clear_ifid` = 1 and `clear_idex` = 1.
   - `hold_pc` = 0, so the PC loads the target.
   - Any load-use or mult/div stall is discarded, since the ID instruction is squashed.
3. **Load-use**: `ex_memread` and `ex_rt` ≠ 0 and (`ex_rt` == `id_rs` or `ex_rt` == `id_rt`).
   - `hold_pc` = 1, `hold_ifid` = 1, `clear_idex` = 1.
4. **Mult/div stall**: `id_md_use` and `md_busy`.
   - Same outputs as load-use: `hold_pc`, `hold_ifid`, `clear_idex`.
5. **Otherwise**: all outputs are 0.

`clear_exmem` is always 0 in this revision; it is reserved for exceptions.

Mult/div FSM, states IDLE, BUSY, DONE:
- **IDLE**:
  - An accepted start moves to BUSY and loads `cnt` ← `MD_LAT`−1.
  - A start is accepted when `ex_md_start` = 1, `mem_wait` = 0 and `ex_branch_taken` = 0.
- **BUSY**:
  - `md_busy` = 1.
  - `cnt` decrements each cycle.
  - When `cnt` == 0, move to DONE.
  - `ex_md_start` is ignored in this state.
  - `mem_wait` does not pause the counter.
- **DONE**:
  - `md_done` = 1 for exactly one cycle and `md_busy` = 0.
  - Next state is IDLE, or BUSY if a start is accepted in this cycle.
- `md_busy` is therefore high for exactly `MD_LAT` consecutive cycles after the accepting edge.

## Timing
- Reset values: FSM = IDLE, `cnt` = 0, `md_busy` = 0, `md_done` = 0, statistics counters = 0.
- With `reset` high, all hold/clear outputs are 0.
- Reset mid-BUSY aborts the operation on that edge; no `md_done` pulse is produced.
- A load-use stall lasts exactly 1 cycle. The next cycle, the load is in MEM and the condition clears naturally.
- Branch flush takes 1 cycle and costs 2 bubbles.
- An mfhi issued immediately after a mult stalls `MD_LAT` cycles and proceeds in the DONE cycle.

## Configuration
`HAZARD_STATS_EN`:
- **Defined**: `stall_cycles` increments every cycle in which `hold_ifid` = 1. `flush_count` increments every cycle in which `clear_ifid` = 1. Both saturate at all-ones and are cleared by `reset`.
- **Undefined**: both ports and their logic are absent.

## Test plan
- Load-use: `ex_memread` = 1, `ex_rt` = 5, `id_rs` = 5 → one cycle of `hold_pc` = `hold_ifid` = `clear_idex` = 1, then all 0.
- Zero register: `ex_memread` = 1, `ex_rt` = 0, `id_rt` = 0 → no stall.
- Branch plus load-use together: `ex_branch_taken` = 1 with a load-use match → `clear_ifid` = `clear_idex` = 1, `hold_pc` = 0.
- Mult/div with `MD_LAT` = 4: start pulse, then `id_md_use` = 1 → `md_busy` high for 4 cycles, ID held for 4 cycles, then `md_done` for 1 cycle with no hold. Reset asserted in BUSY cycle 2 → IDLE next cycle, no `md_done`.
- `mem_wait` for 3 cycles during a branch → all `hold_*` = 1 and no clears; the flush occurs on the cycle after `mem_wait` falls. With `HAZARD_STATS_EN`: `stall_cycles` = 3, `flush_count` = 1.
